hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/mdu_timer.sv | 39 +++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: pipeline register indices, hazard FSM
// states and a helper that builds one-hot masks over the pipeline registers.
package pipe_ctrl_pkg;

    localparam int NSTAGE = 4;
    localparam int IFID   = 0;
    localparam int IDEX   = 1;
    localparam int EXMEM  = 2;
    localparam int MEMWB  = 3;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hc_state_e;

    // One bit set at the given pipeline register position.
    function automatic logic [NSTAGE-1:0] stg(input int idx);
        return NSTAGE'(1) << idx;
    endfunction

endpackage

// File: rtl/mdu_timer.sv
// Down-counter that times a multiply/divide freeze. Loads a latency value,
// counts towards zero one step per cycle unless held, and flags zero.
module mdu_timer #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] lat_i,
    input  logic          hold_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at zero, so the counter idles at 0 between operations.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = lat_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory wait, mul/div freeze, taken
// branch and load-use hazards into PC hold plus per-register stall/flush.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter  int MUL_LAT = 4,
    parameter  int DIV_LAT = 32,
    localparam int CW      = $clog2(DIV_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          ex_is_load,
    input  logic [4:0]    ex_rd,
    input  logic          ex_branch_taken,
    input  logic          ex_mdu_start,
    input  logic          ex_mdu_is_div,
    input  logic          dmem_req,
    input  logic          dmem_ready,
    output logic          pc_stall,
    output logic [3:0]    stall,
    output logic [3:0]    flush,
    output logic          mdu_busy,
    output logic          mdu_done,
    output logic [31:0]   stall_cnt,
    output logic          dbg_state,
    output logic [CW-1:0] dbg_cnt
);

    hc_state_e     state_q;
    hc_state_e     state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lat_m1;
    logic          cnt_zero;
    logic          mem_wait;
    logic          load_use;
    logic          mdu_load;
    logic          mdu_stall;
    logic [31:0]   stall_cnt_q;

    // Memory handshake: the MEM access is outstanding on every cycle dmem_req
    // is high and completes in the cycle dmem_ready is also high; until then
    // everything up to EX/MEM holds and a bubble is pushed into MEM/WB.
    assign mem_wait = dmem_req && !dmem_ready;

    assign lat_m1 = ex_mdu_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    mdu_timer #(
        .CW(CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (mdu_load),
        .lat_i  (lat_m1),
        .hold_i (mem_wait),
        .cnt_o  (cnt),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        mdu_load  = 1'b0;
        mdu_stall = 1'b0;
        mdu_done  = 1'b0;
        pc_stall  = 1'b0;
        stall     = '0;
        flush     = '0;
        if (rst) begin
            state_d = RUN;
        end else if (mem_wait) begin
            pc_stall = 1'b1;
            stall    = stg(IFID) | stg(IDEX) | stg(EXMEM);
            flush    = stg(MEMWB);
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_mdu_start) begin
                        mdu_load  = 1'b1;
                        mdu_stall = 1'b1;
                        // Single-cycle latency completes in the start cycle.
                        if (lat_m1 == '0) begin
                            mdu_done = 1'b1;
                        end else begin
                            state_d = MDU_BUSY;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (!cnt_zero) begin
                        mdu_stall = 1'b1;
                    end else begin
                        mdu_done = 1'b1;
                        state_d  = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            if (mdu_stall) begin
                pc_stall = 1'b1;
                stall    = stg(IFID) | stg(IDEX);
                flush    = stg(EXMEM);
            end else if (ex_branch_taken) begin
                flush = stg(IFID) | stg(IDEX);
            end else if (load_use) begin
                pc_stall = 1'b1;
                stall    = stg(IFID);
                flush    = stg(IDEX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (pc_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign mdu_busy  = !rst && (state_q == MDU_BUSY);
    assign stall_cnt = stall_cnt_q;
    assign dbg_state = (state_q == MDU_BUSY);
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MUL 4/DIV 32 and MUL 1/DIV 7) share
// stimulus and are checked every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int A_MUL = 4;
    localparam int A_DIV = 32;
    localparam int B_MUL = 1;
    localparam int B_DIV = 7;

    logic clk;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_uses_rs, id_uses_rt, ex_is_load, ex_branch_taken;
    logic ex_mdu_start, ex_mdu_is_div, dmem_req, dmem_ready;

    logic        pc_stall_w [2];
    logic [3:0]  stall_w    [2];
    logic [3:0]  flush_w    [2];
    logic        mdu_busy_w [2];
    logic        mdu_done_w [2];
    logic        dbg_state_w[2];
    logic [31:0] stall_cnt_w[2];
    logic [5:0]  cnt_a;
    logic [2:0]  cnt_b;

    int n_cmp;
    int n_bad;

    // Model: whether an operation is in flight, how many freeze cycles of it
    // have elapsed, its latency, and the running count of PC-hold cycles.
    bit          m_inflight[2];
    int          m_pos     [2];
    int          m_lat     [2];
    logic [31:0] m_scnt    [2];

    hazard_ctrl #(.MUL_LAT(A_MUL), .DIV_LAT(A_DIV)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall_w[0]), .stall(stall_w[0]), .flush(flush_w[0]),
        .mdu_busy(mdu_busy_w[0]), .mdu_done(mdu_done_w[0]),
        .stall_cnt(stall_cnt_w[0]), .dbg_state(dbg_state_w[0]), .dbg_cnt(cnt_a)
    );

    hazard_ctrl #(.MUL_LAT(B_MUL), .DIV_LAT(B_DIV)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall_w[1]), .stall(stall_w[1]), .flush(flush_w[1]),
        .mdu_busy(mdu_busy_w[1]), .mdu_done(mdu_done_w[1]),
        .stall_cnt(stall_cnt_w[1]), .dbg_state(dbg_state_w[1]), .dbg_cnt(cnt_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t: got 0x%0h, expected 0x%0h", nm, inst, $time, act, exp);
        end
    endtask

    // ---------------- model + compare process ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit          e_pc, e_busy, e_done, frz, lu;
            logic [3:0]  e_st, e_fl;
            logic [31:0] e_cnt, e_scnt, act_cnt;
            int          lat;
            e_pc = 0; e_done = 0; frz = 0; e_st = 4'b0000; e_fl = 4'b0000;
            e_busy = m_inflight[i];
            e_cnt  = m_inflight[i] ? 32'(m_lat[i] - m_pos[i]) : 32'd0;
            lu = ex_is_load && (ex_rd != 5'd0) &&
                 ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
            if (rst) begin
                e_busy = 0; e_cnt = 0; e_scnt = 0;
                m_inflight[i] = 0; m_pos[i] = 0; m_scnt[i] = 0;
            end else begin
                if (dmem_req && !dmem_ready) begin
                    e_pc = 1; e_st = 4'b0111; e_fl = 4'b1000;
                end else begin
                    if (!m_inflight[i]) begin
                        if (ex_mdu_start) begin
                            if (i == 0) lat = ex_mdu_is_div ? A_DIV : A_MUL;
                            else        lat = ex_mdu_is_div ? B_DIV : B_MUL;
                            frz    = 1;
                            e_done = (lat == 1);
                            if (lat > 1) begin
                                m_inflight[i] = 1; m_lat[i] = lat; m_pos[i] = 1;
                            end
                        end
                    end else if (m_pos[i] < m_lat[i]) begin
                        frz = 1;
                        m_pos[i]++;
                    end else begin
                        e_done = 1;
                        m_inflight[i] = 0;
                    end
                    if (frz) begin
                        e_pc = 1; e_st = 4'b0011; e_fl = 4'b0100;
                    end else if (ex_branch_taken) begin
                        e_fl = 4'b0011;
                    end else if (lu) begin
                        e_pc = 1; e_st = 4'b0001; e_fl = 4'b0010;
                    end
                end
                e_scnt = m_scnt[i];
                if (e_pc) m_scnt[i] = m_scnt[i] + 32'd1;
            end
            act_cnt = (i == 0) ? {26'd0, cnt_a} : {29'd0, cnt_b};
            chk("pc_stall",  i, {31'd0, pc_stall_w[i]}, {31'd0, e_pc});
            chk("stall",     i, {28'd0, stall_w[i]},    {28'd0, e_st});
            chk("flush",     i, {28'd0, flush_w[i]},    {28'd0, e_fl});
            chk("mdu_busy",  i, {31'd0, mdu_busy_w[i]}, {31'd0, e_busy});
            chk("dbg_state", i, {31'd0, dbg_state_w[i]}, {31'd0, e_busy});
            chk("mdu_done",  i, {31'd0, mdu_done_w[i]}, {31'd0, e_done});
            chk("cnt",       i, act_cnt, e_cnt);
            chk("stall_cnt", i, stall_cnt_w[i], e_scnt);
            chk("stall_and_flush", i, {28'd0, stall_w[i] & flush_w[i]}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_in();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0; ex_branch_taken = 0;
        ex_mdu_start = 0; ex_mdu_is_div = 0; dmem_req = 0; dmem_ready = 1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            idle_in(); settle(); next();
        end
    endtask

    task automatic do_reset();
        rst = 1; idle_in(); settle(); next(); rst = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_is_load = 1; ex_rd = rd; id_rs = 8; id_uses_rs = 1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int st_n, bs_n, dn_n, dn_idx, b_st;
        n_cmp = 0; n_bad = 0;
        rst = 1; idle_in();
        settle();
        chk("rst_pc_stall", 0, {31'd0, pc_stall_w[0]}, 0);
        chk("rst_stall", 0, {28'd0, stall_w[0] | flush_w[0]}, 0);
        chk("rst_stall_cnt", 0, stall_cnt_w[0], 0);
        next(); settle(); next(); rst = 0;

        // load-use on rs, then gone, then rd = 0
        set_lu(5'd8); settle();
        chk("lu_pc", 0, {31'd0, pc_stall_w[0]}, 1);
        chk("lu_stall", 0, {28'd0, stall_w[0]}, 32'h1);
        chk("lu_flush", 0, {28'd0, flush_w[0]}, 32'h2);
        next(); idle_in(); settle();
        chk("lu_one_cycle", 0, {31'd0, pc_stall_w[0]}, 0);
        next(); set_lu(5'd0); id_rs = 0; settle();
        chk("lu_r0", 0, {28'd0, stall_w[0]} | {31'd0, pc_stall_w[0]}, 0);
        next(); idle_in(); ex_is_load = 1; ex_rd = 5; id_rs = 5; id_rt = 5; id_uses_rt = 1;
        settle();
        chk("lu_rt", 0, {28'd0, stall_w[0]}, 32'h1);
        next(); id_uses_rt = 0; settle();
        chk("lu_unused", 0, {31'd0, pc_stall_w[0]}, 0);
        next();

        // branch beats load-use
        idle_in(); set_lu(5'd8); ex_branch_taken = 1; settle();
        chk("br_flush", 0, {28'd0, flush_w[0]}, 32'h3);
        chk("br_pc", 0, {31'd0, pc_stall_w[0]}, 0);
        chk("br_stall", 0, {28'd0, stall_w[0]}, 0);
        next();

        // divide, DIV_LAT = 32 on instance a
        do_reset();
        st_n = 0; bs_n = 0; dn_n = 0; dn_idx = -1; b_st = 0;
        for (int c = 0; c < 40; c++) begin
            idle_in(); ex_mdu_start = (c == 0); ex_mdu_is_div = 1; settle();
            if (pc_stall_w[0]) st_n++;
            if (pc_stall_w[0] && mdu_busy_w[0]) bs_n++;
            if (mdu_done_w[0]) begin dn_n++; dn_idx = c; end
            if (pc_stall_w[1]) b_st++;
            next();
        end
        chk("div_stalls", 0, st_n, 32);
        chk("div_busy_stalls", 0, bs_n, 31);
        chk("div_done_cycle", 0, dn_idx, 32);
        chk("div_done_count", 0, dn_n, 1);
        chk("div_stall_cnt", 0, stall_cnt_w[0], 32);
        chk("div_stalls", 1, b_st, 7);

        // multiply: instance b has latency 1
        idle_in(); ex_mdu_start = 1; settle();
        chk("mul1_pc", 1, {31'd0, pc_stall_w[1]}, 1);
        chk("mul1_done", 1, {31'd0, mdu_done_w[1]}, 1);
        chk("mul1_busy", 1, {31'd0, mdu_busy_w[1]}, 0);
        chk("mul4_done", 0, {31'd0, mdu_done_w[0]}, 0);
        next(); idle_in(); settle();
        chk("mul1_after", 1, {31'd0, pc_stall_w[1] | mdu_busy_w[1]}, 0);
        chk("mul4_busy", 0, {31'd0, mdu_busy_w[0]}, 1);
        next(); idle_cycles(8);

        // memory wait in MDU_BUSY at cnt = 5
        idle_in(); ex_mdu_start = 1; ex_mdu_is_div = 1; settle(); next();
        idle_cycles(26);
        for (int c = 0; c < 3; c++) begin
            idle_in(); dmem_req = 1; dmem_ready = 0; settle();
            chk("mw_stall", 0, {28'd0, stall_w[0]}, 32'h7);
            chk("mw_flush", 0, {28'd0, flush_w[0]}, 32'h8);
            chk("mw_cnt", 0, {26'd0, cnt_a}, 5);
            next();
        end
        idle_in(); dmem_req = 1; settle();
        chk("mw_resume_stall", 0, {28'd0, stall_w[0]}, 32'h3);
        chk("mw_resume_cnt", 0, {26'd0, cnt_a}, 5);
        next(); idle_in(); settle();
        chk("mw_dec_cnt", 0, {26'd0, cnt_a}, 4);
        next(); idle_cycles(10);

        // start deferred by memory wait
        for (int c = 0; c < 2; c++) begin
            idle_in(); ex_mdu_start = 1; dmem_req = 1; dmem_ready = 0; settle(); next();
        end
        idle_in(); ex_mdu_start = 1; settle();
        chk("defer_start", 0, {28'd0, stall_w[0]}, 32'h3);
        next(); idle_in(); settle();
        chk("defer_busy", 0, {31'd0, mdu_busy_w[0]}, 1);
        next(); idle_cycles(12);

        // reset at cnt = 10
        idle_in(); ex_mdu_start = 1; ex_mdu_is_div = 1; settle(); next();
        idle_cycles(21);
        chk("pre_rst_cnt", 0, {26'd0, cnt_a}, 10);
        rst = 1; settle();
        chk("rst_mid_pc", 0, {31'd0, pc_stall_w[0] | mdu_busy_w[0] | mdu_done_w[0]}, 0);
        chk("rst_mid_vec", 0, {28'd0, stall_w[0] | flush_w[0]}, 0);
        chk("rst_mid_scnt", 0, stall_cnt_w[0], 0);
        next(); rst = 0; set_lu(5'd8); settle();
        chk("post_rst_lu", 0, {28'd0, stall_w[0]}, 32'h1);
        chk("post_rst_state", 0, {31'd0, dbg_state_w[0]}, 0);
        chk("post_rst_scnt", 0, stall_cnt_w[0], 0);
        next();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rst             = ($urandom_range(0, 299) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs      = $urandom_range(0, 1) == 1;
            id_uses_rt      = $urandom_range(0, 1) == 1;
            ex_is_load      = $urandom_range(0, 9) < 3;
            ex_branch_taken = $urandom_range(0, 9) == 0;
            ex_mdu_start    = $urandom_range(0, 19) == 0;
            ex_mdu_is_div   = $urandom_range(0, 1) == 1;
            dmem_req        = $urandom_range(0, 4) == 0;
            dmem_ready      = $urandom_range(0, 1) == 1;
            settle(); next();
        end
        rst = 0;
        idle_cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
